// File: rtl/bpc_sng_gen.sv
// Bit-plane-coded SNG: N unipolar streams from binary probabilities plus NC p=0.5 streams, length set by S.
// Latency: outputs are combinational from the registered mixed-radix counter; done rises L cycles after reset.
// Backpressure: none; advances every cycle until done, then holds until reset.
module bpc_sng_gen #(
    parameter int W        = 6,
    parameter int N        = 2,
    parameter int NC       = 1,
    parameter int CORR     = 0,
    parameter int S_GROUPS = (CORR != 0) ? 1 : N,
    parameter int TW       = S_GROUPS * W + NC
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N-1:0][W-1:0]          Bxs,
    input  logic [S_GROUPS-1:0][W-1:0]   S,
    output logic [N-1:0]                 Xs,
    output logic [NC-1:0]                Xcs,
    output logic                         done
);

    // Counter layout, LSB first: cnt_c (NC bits), then one W-bit segment per group.
    logic [TW-1:0]                cnt;
    logic [TW-1:0]                cnt_nxt;
    logic [NC-1:0]                cnt_c;
    logic [S_GROUPS-1:0][W-1:0]   seg;
    logic [S_GROUPS-1:0]          at_term;
    logic [S_GROUPS:0]            carry;
    logic [N-1:0]                 hit;

    assign cnt_c = cnt[NC-1:0];
    assign seg   = cnt[TW-1:NC];

    // The >= compare keeps a segment bounded even if S is lowered below its value mid-stream.
    always_comb begin
        cnt_nxt          = cnt;
        carry            = '0;
        at_term          = '0;
        cnt_nxt[NC-1:0]  = cnt_c + NC'(1);
        carry[0]         = &cnt_c;
        for (int g = 0; g < S_GROUPS; g++) begin
            at_term[g] = (seg[g] >= S[g]);
            if (carry[g]) begin
                cnt_nxt[NC+g*W +: W] = at_term[g] ? '0 : seg[g] + W'(1);
            end
            carry[g+1] = carry[g] && at_term[g];
        end
    end

    // A carry out of the top segment marks the final state: latch done and freeze the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (!done) begin
            if (carry[S_GROUPS]) begin
                done <= 1'b1;
            end else begin
                cnt  <= cnt_nxt;
            end
        end
    end

    // Trailing-ones count t of the segment selects bit-plane W-1-t; all-ones segment yields 0.
    always_comb begin
        Xs  = '0;
        hit = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < W; j++) begin
                if (!hit[i] && !seg[(CORR != 0) ? 0 : i][j]) begin
                    hit[i] = 1'b1;
                    Xs[i]  = Bxs[i][W-1-j];
                end
            end
        end
        if (done) begin
            Xs = '0;
        end
    end

    assign Xcs = done ? '0 : cnt_c;

endmodule

// File: tb/tb_bpc_sng_gen.sv
// Directed bench for bpc_sng_gen: one independent-segment instance and one correlated instance,
// measuring stream length, ones counts, joint ones and post-done behaviour.
module tb_bpc_sng_gen;

    logic              clk = 1'b0;
    always #5 clk = ~clk;

    // Independent segments (CORR=0)
    logic              rst0_n;
    logic [1:0][5:0]   bxs0;
    logic [1:0][5:0]   s0;
    logic [1:0]        xs0;
    logic [0:0]        xcs0;
    logic              done0;

    // Shared segment (CORR=1)
    logic              rst1_n;
    logic [1:0][5:0]   bxs1;
    logic [0:0][5:0]   s1;
    logic [1:0]        xs1;
    logic [0:0]        xcs1;
    logic              done1;

    bpc_sng_gen #(.W(6), .N(2), .NC(1), .CORR(0), .S_GROUPS(2), .TW(13)) u_dut0 (
        .clk   (clk),
        .rst_n (rst0_n),
        .Bxs   (bxs0),
        .S     (s0),
        .Xs    (xs0),
        .Xcs   (xcs0),
        .done  (done0)
    );

    bpc_sng_gen #(.W(6), .N(2), .NC(1), .CORR(1), .S_GROUPS(1), .TW(7)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .Bxs   (bxs1),
        .S     (s1),
        .Xs    (xs1),
        .Xcs   (xcs1),
        .done  (done1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    int len, ones0, ones1, both, xcs_ones, xcs_bad;

    // Assert reset for a few ns, then release just after a falling edge so cycle 0 is sampled next.
    task automatic restart(input bit sel);
        @(negedge clk);
        if (sel) rst1_n = 1'b0; else rst0_n = 1'b0;
        #2;
        if (sel) rst1_n = 1'b1; else rst0_n = 1'b1;
    endtask

    // Samples each cycle 1 ns after the falling edge until done is seen or the budget runs out.
    task automatic run_stream(input bit sel, input int lim);
        logic [1:0] xs;
        logic       xc;
        logic       dn;
        len = -1; ones0 = 0; ones1 = 0; both = 0; xcs_ones = 0; xcs_bad = 0;
        for (int c = 0; c < lim; c++) begin
            #1;
            xs = sel ? xs1 : xs0;
            xc = sel ? xcs1[0] : xcs0[0];
            dn = sel ? done1 : done0;
            if (dn) begin
                len = c;
                break;
            end
            ones0    += int'(xs[0]);
            ones1    += int'(xs[1]);
            both     += int'(xs[0] & xs[1]);
            xcs_ones += int'(xc);
            if (xc != c[0]) xcs_bad++;
            @(negedge clk);
        end
    endtask

    int bad;

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        bxs0 = {6'd32, 6'd32}; s0 = {6'd31, 6'd31};
        bxs1 = {6'd16, 6'd48}; s1 = {6'd63};
        #12;
        // Reset state: count 0 selects the MSB plane; 32 has MSB set
        check("rst_done", done0, 0);
        check("rst_xcs", xcs0, 0);
        check("rst_xs", xs0, 2'b11);

        // Test 1: Bxs={32,32}, S={31,31}, L=2*32*32
        restart(0);
        run_stream(0, 2100);
        check("t1_len", len, 2048);
        check("t1_ones0", ones0, 1024);
        check("t1_ones1", ones1, 1024);
        check("t1_xcs_ones", xcs_ones, 1024);
        check("t1_xcs_alt", xcs_bad, 0);
        check("t1_both", both, 512);

        // Test 2: full precision, Bxs={45,17} (index 0 = 45)
        bxs0 = {6'd17, 6'd45}; s0 = {6'd63, 6'd63};
        restart(0);
        run_stream(0, 8300);
        check("t2_len", len, 8192);
        check("t2_ones0", ones0, 45 * 128);
        check("t2_ones1", ones1, 17 * 128);

        // Test 3: S=7; values 0..6 give planes 5,4,3 (4+0+1 ones) and the terminal
        // value 7 has three trailing ones, selecting plane 2 (set in 45): 6 of 8, L=128
        bxs0 = {6'd45, 6'd45}; s0 = {6'd7, 6'd7};
        restart(0);
        run_stream(0, 200);
        check("t3_len", len, 128);
        check("t3_ones0", ones0, 96);
        check("t3_ones1", ones1, 96);

        // Test 4: correlated instance, Bxs={48,16}, S={63}
        restart(1);
        run_stream(1, 200);
        check("t4_len", len, 128);
        check("t4_ones0", ones0, 96);
        check("t4_ones1", ones1, 32);
        check("t4_both", both, 32);

        // Test 5: S={0,0}, Bxs[0]=45 (MSB 1), Bxs[1]=17 (MSB 0)
        bxs0 = {6'd17, 6'd45}; s0 = {6'd0, 6'd0};
        restart(0);
        run_stream(0, 20);
        check("t5_len", len, 2);
        check("t5_ones0", ones0, 2);
        check("t5_ones1", ones1, 0);
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            if (!done0 || xs0 != 2'b00 || xcs0 != 1'b0) bad++;
        end
        check("t5_hold", bad, 0);

        // Test 6: asynchronous reset at cycle 500 of the test 1 stream
        bxs0 = {6'd32, 6'd32}; s0 = {6'd31, 6'd31};
        restart(0);
        repeat (500) @(negedge clk);
        #1;
        check("t6_pre_done", done0, 0);
        #2;
        rst0_n = 1'b0;
        #1;
        check("t6_async_done", done0, 0);
        check("t6_async_xcs", xcs0, 0);
        check("t6_async_xs", xs0, 2'b11);
        @(posedge clk); #1;
        check("t6_held_xcs", xcs0, 0);
        @(negedge clk);
        rst0_n = 1'b1;
        run_stream(0, 2100);
        check("t6_len", len, 2048);
        check("t6_ones0", ones0, 1024);
        check("t6_ones1", ones1, 1024);
        check("t6_both", both, 512);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
